// File: rtl/modport_fifo_if.sv
// Handshake bundle between the FIFO and its producer/consumer agents.
// The master modport is the agent side; the slave modport is the FIFO itself.
interface modport_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  full, rd_data, empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output full, rd_data, empty, count, overflow, underflow
    );
endinterface

// File: rtl/modport_fifo.sv
// Single-clock FIFO with registered read data, registered full/empty/count
// and one-cycle overflow/underflow pulses for rejected requests.
module modport_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    modport_fifo_if.slave     bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_WIDTH:0]   wptr_reg, wptr_next;
    logic [ADDR_WIDTH:0]   rptr_reg, rptr_next;
    logic [ADDR_WIDTH:0]   count_reg;
    logic                  full_reg, empty_reg;
    logic                  overflow_reg, underflow_reg;
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic                  wr_accept, rd_accept;

    assign wr_accept = bus.wr_en & ~full_reg;
    assign rd_accept = bus.rd_en & ~empty_reg;

    always_comb begin
        wptr_next = wptr_reg + {{ADDR_WIDTH{1'b0}}, wr_accept};
        rptr_next = rptr_reg + {{ADDR_WIDTH{1'b0}}, rd_accept};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
            full_reg      <= 1'b0;
            empty_reg     <= 1'b1;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            rd_data_reg   <= '0;
        end else begin
            wptr_reg      <= wptr_next;
            rptr_reg      <= rptr_next;
            // Modular pointer difference is exactly the occupancy 0..DEPTH.
            count_reg     <= wptr_next - rptr_next;
            empty_reg     <= (wptr_next == rptr_next);
            full_reg      <= (wptr_next[ADDR_WIDTH-1:0] == rptr_next[ADDR_WIDTH-1:0]) &&
                             (wptr_next[ADDR_WIDTH] != rptr_next[ADDR_WIDTH]);
            overflow_reg  <= bus.wr_en & full_reg;
            underflow_reg <= bus.rd_en & empty_reg;
            if (rd_accept) begin
                rd_data_reg <= mem[rptr_reg[ADDR_WIDTH-1:0]];
            end
        end
    end

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wptr_reg[ADDR_WIDTH-1:0]] <= bus.wr_data;
        end
    end

    assign bus.full      = full_reg;
    assign bus.empty     = empty_reg;
    assign bus.count     = count_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.underflow = underflow_reg;
    assign bus.rd_data   = rd_data_reg;
endmodule

// File: tb/tb_modport_fifo.sv
// Directed bench for modport_fifo: a vector table for fill/drain/boundary
// cases plus hand-written wrap, streaming and mid-operation reset sequences.
module tb_modport_fifo;
    logic clk;
    logic rst;

    modport_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) fifo_bus ();

    modport_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (fifo_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       wr_en;
        logic       rd_en;
        logic [7:0] wr_data;
        logic [7:0] exp_rd;
        logic [4:0] exp_count;
        logic       exp_full;
        logic       exp_empty;
        logic       exp_ovf;
        logic       exp_udf;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic w, input logic r, input logic [7:0] d,
                                input logic [7:0] er, input logic [4:0] c,
                                input logic f, input logic e, input logic o, input logic u);
        vec_t v;
        v.wr_en = w; v.rd_en = r; v.wr_data = d; v.exp_rd = er; v.exp_count = c;
        v.exp_full = f; v.exp_empty = e; v.exp_ovf = o; v.exp_udf = u;
        vecs.push_back(v);
    endfunction

    // Drive one request cycle, then sample just after the edge.
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        fifo_bus.wr_en   = w;
        fifo_bus.rd_en   = r;
        fifo_bus.wr_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag, input logic [7:0] er, input logic [4:0] c,
                                input logic f, input logic e, input logic o, input logic u);
        check({tag, ".rd_data"},   32'(fifo_bus.rd_data),   32'(er));
        check({tag, ".count"},     32'(fifo_bus.count),     32'(c));
        check({tag, ".full"},      32'(fifo_bus.full),      32'(f));
        check({tag, ".empty"},     32'(fifo_bus.empty),     32'(e));
        check({tag, ".overflow"},  32'(fifo_bus.overflow),  32'(o));
        check({tag, ".underflow"}, 32'(fifo_bus.underflow), 32'(u));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] model[$];
        logic [7:0] exp_byte;
        logic [7:0] data;
        logic       w, r, up;
        int         wr_n, rd_n, occ, cyc;

        // Table: fill, overflow, drain, underflow, simultaneous at empty and full.
        for (int i = 0; i < 16; i++) add(1, 0, 8'(i), 8'h00, 5'(i + 1), i == 15, 0, 0, 0);
        add(1, 0, 8'hAA, 8'h00, 5'd16, 1, 0, 1, 0);
        add(0, 0, 8'h00, 8'h00, 5'd16, 1, 0, 0, 0);
        for (int i = 0; i < 16; i++) add(0, 1, 8'h00, 8'(i), 5'(15 - i), 0, i == 15, 0, 0);
        add(0, 1, 8'h00, 8'h0F, 5'd0, 0, 1, 0, 1);
        add(0, 0, 8'h00, 8'h0F, 5'd0, 0, 1, 0, 0);
        add(1, 1, 8'h77, 8'h0F, 5'd1, 0, 0, 0, 1);
        add(0, 1, 8'h00, 8'h77, 5'd0, 0, 1, 0, 0);
        for (int i = 0; i < 16; i++) add(1, 0, 8'(i), 8'h77, 5'(i + 1), i == 15, 0, 0, 0);
        add(1, 1, 8'h55, 8'h00, 5'd15, 0, 0, 1, 0);
        for (int i = 1; i < 16; i++) add(0, 1, 8'h00, 8'(i), 5'(15 - i), 0, i == 15, 0, 0);
        add(0, 1, 8'h00, 8'h0F, 5'd0, 0, 1, 0, 1);

        fifo_bus.wr_en   = 1'b0;
        fifo_bus.rd_en   = 1'b0;
        fifo_bus.wr_data = 8'h00;
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_status("reset0", 8'h00, 5'd0, 0, 1, 0, 0);
        $display("[TB] initial reset checked before first edge");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].wr_en, vecs[i].rd_en, vecs[i].wr_data);
            check_status($sformatf("vec%0d", i), vecs[i].exp_rd, vecs[i].exp_count,
                         vecs[i].exp_full, vecs[i].exp_empty, vecs[i].exp_ovf, vecs[i].exp_udf);
            $display("[TB] vec %0d wr=%0b rd=%0b din=%02h -> rd_data=%02h count=%0d full=%0b empty=%0b ovf=%0b udf=%0b",
                     i, vecs[i].wr_en, vecs[i].rd_en, vecs[i].wr_data, fifo_bus.rd_data,
                     fifo_bus.count, fifo_bus.full, fifo_bus.empty, fifo_bus.overflow, fifo_bus.underflow);
        end

        // Wrap-around: 40 words with occupancy swinging between 3 and 10.
        wr_n = 0; rd_n = 0; up = 1'b1; cyc = 0;
        while (rd_n < 40 && cyc < 400) begin
            occ = wr_n - rd_n;
            if (wr_n == 40) begin
                w = 1'b0; r = 1'b1;
            end else if (up) begin
                w = 1'b1; r = (cyc % 3 == 2) && (occ >= 3);
            end else begin
                w = 1'b0; r = 1'b1;
            end
            data = 8'(wr_n * 7 + 3);
            step(w, r, data);
            if (w) begin
                model.push_back(data);
                wr_n++;
            end
            if (r) begin
                exp_byte = model.pop_front();
                rd_n++;
                check($sformatf("wrap%0d.rd_data", cyc), 32'(fifo_bus.rd_data), 32'(exp_byte));
            end
            check($sformatf("wrap%0d.count", cyc), 32'(fifo_bus.count), 32'(wr_n - rd_n));
            $display("[TB] wrap %0d wr=%0b rd=%0b din=%02h -> rd_data=%02h count=%0d",
                     cyc, w, r, data, fifo_bus.rd_data, fifo_bus.count);
            occ = wr_n - rd_n;
            if (occ >= 10) up = 1'b0;
            if (occ <= 3) up = 1'b1;
            cyc++;
        end
        check("wrap.reads_done", 32'(rd_n), 32'd40);

        // Streaming: one word preloaded, then simultaneous read+write each cycle.
        step(1, 0, 8'hC0);
        check("stream.preload.count", 32'(fifo_bus.count), 32'd1);
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 8'(8'hC1 + i));
            check_status($sformatf("stream%0d", i), 8'(8'hC0 + i), 5'd1, 0, 0, 0, 0);
            $display("[TB] stream %0d din=%02h -> rd_data=%02h count=%0d",
                     i, 8'(8'hC1 + i), fifo_bus.rd_data, fifo_bus.count);
        end

        // Mid-operation reset with the FIFO half full, observed before any edge.
        for (int i = 0; i < 7; i++) step(1, 0, 8'(8'h20 + i));
        step(0, 0, 8'h00);
        check("prereset.count", 32'(fifo_bus.count), 32'd8);
        #2 rst = 1'b1;
        #1;
        check_status("midreset", 8'h00, 5'd0, 0, 1, 0, 0);
        $display("[TB] mid-operation reset -> rd_data=%02h count=%0d full=%0b empty=%0b",
                 fifo_bus.rd_data, fifo_bus.count, fifo_bus.full, fifo_bus.empty);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        step(1, 0, 8'h3C);
        check_status("postreset.wr", 8'h00, 5'd1, 0, 0, 0, 0);
        step(0, 1, 8'h00);
        check_status("postreset.rd", 8'h3C, 5'd0, 0, 1, 0, 0);
        $display("[TB] post-reset write/read -> rd_data=%02h count=%0d", fifo_bus.rd_data, fifo_bus.count);
        step(0, 0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/modport_fifo.md
Name: modport_fifo

Overview:
- Single-clock synchronous FIFO, 16 entries x 8 bits by default.
- Sits between a write-side producer agent and a read-side consumer agent.
- Accepts data with wr_en and returns it in order with rd_en.
- Reports full/empty status, occupancy count, and single-cycle overflow/underflow error pulses.

Parameters:
DATA_WIDTH, 8, width of wr_data/rd_data in bits
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (16 by default)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  reset, asynchronous assert, active-high
wr_en  input  1  write request
wr_data  input  DATA_WIDTH  write data, sampled with wr_en
full  output  1  FIFO holds DEPTH entries
rd_en  input  1  read request
rd_data  output  DATA_WIDTH  read data, registered
empty  output  1  FIFO holds 0 entries
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  one-cycle pulse: previous-cycle write rejected
underflow  output  1  one-cycle pulse: previous-cycle read rejected

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- While rst=1 (effective immediately, no clock needed):
  - write/read pointers = 0, count = 0
  - empty = 1, full = 0
  - rd_data = 0, overflow = 0, underflow = 0
  - storage contents don't-care
- Pointers are ADDR_WIDTH+1 bits (MSB = wrap bit).
  - Memory index = low ADDR_WIDTH bits.
  - Pointers wrap naturally modulo 2*DEPTH.
- Accept rules, evaluated at each rising edge using current registered state:
  - Write accepted iff wr_en=1 and full=0. mem[wptr] <= wr_data; wptr++.
  - Read accepted iff rd_en=1 and empty=0. rd_data <= mem[rptr]; rptr++.
- Read latency: rd_data updates at the edge where the read is accepted, visible one cycle after rd_en is asserted. rd_data holds its last value when no read is accepted.
- No fall-through: a word written at edge N is readable at the earliest from edge N+1.
- Status outputs:
  - count: +1 on write only, -1 on read only, unchanged on both or neither.
  - full and empty are registered, derived from next pointer values.
  - empty = (wptr == rptr).
  - full = (low bits equal, wrap bits differ). Equivalent to count == DEPTH.
- Simultaneous wr_en and rd_en:
  - When 0 < count < DEPTH: both accepted, count unchanged.
  - When full: read accepted, write rejected; count goes to DEPTH-1, overflow pulses.
  - When empty: write accepted, read rejected; count goes to 1, underflow pulses, rd_data unchanged.
- Error pulses:
  - overflow = 1 for exactly the cycle after an edge with wr_en=1 and full=1.
  - underflow = 1 likewise for rd_en=1 and empty=1.
  - Neither pulse alters any other state.
- Reset mid-operation: all contents are discarded and outputs return to reset values. Operation resumes on the first edge after rst deasserts.
- X on wr_data when wr_en=0 is ignored.

Test Plan:
- Reset: assert rst with FIFO half full -> empty=1, full=0, count=0, rd_data=0 immediately, without a clock edge.
- Fill: 16 writes 0x00..0x0F -> count steps 1..16; full=1 after the 16th edge; empty=0 after the 1st.
  - 17th write 0xAA -> overflow=1 for one cycle, count stays 16.
- Drain: 16 reads -> rd_data = 0x00..0x0F in order, each one cycle after its rd_en; empty=1 after the last.
  - Extra read -> underflow=1 for one cycle, rd_data stays 0x0F.
- Simultaneous at boundaries:
  - Full plus wr_en&rd_en (wr_data=0x55) -> rd_data=0x00, count=15, overflow=1, 0x55 not stored.
  - Empty plus both (wr_data=0x77) -> count=1, underflow=1; next read returns 0x77.
- Wrap-around: 40 writes interleaved with reads, occupancy kept between 3 and 10 -> all 40 values are returned in order across pointer wrap, and count always equals writes minus reads.
- Streaming: after 1 preload, wr_en=rd_en=1 for 20 cycles -> count stays 1, full and empty stay 0, and the output sequence lags the input by one word.
